// File: rtl/mips_alu_muldiv_if.sv
// Function codes and the handshake bundle between the ALU stage and the
// iterative multiply/divide unit.
package mips_alu_muldiv_pkg;
  typedef enum logic [3:0] {
    F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU,
    F_SLL, F_SRL, F_SRA, F_MULU, F_MULS, F_DIVU, F_DIVS, F_LUI
  } func_t;
endpackage

interface mips_alu_muldiv_if #(parameter int DATA_W = 32);
  import mips_alu_muldiv_pkg::*;

  logic              start;
  logic              flush;
  func_t             func;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic              busy;
  logic              valid;
  logic [DATA_W-1:0] res_hi;
  logic [DATA_W-1:0] res_lo;
  logic              div_zero;

  modport master (
    output start, flush, func, data1, data2,
    input  busy, valid, res_hi, res_lo, div_zero
  );

  modport slave (
    input  start, flush, func, data1, data2,
    output busy, valid, res_hi, res_lo, div_zero
  );
endinterface

// File: rtl/mips_alu_muldiv.sv
// Radix-2 iterative multiply/divide unit: shift-add multiply, restoring divide,
// one sign-fix cycle, fixed DATA_W+2 cycle latency from accept to valid.
module mips_alu_muldiv #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input logic              clk,
  input logic              rst,
  mips_alu_muldiv_if.slave bus
);
  import mips_alu_muldiv_pkg::*;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] acc_hi;
  logic [DATA_W-1:0] acc_lo;
  logic [DATA_W-1:0] opnd;
  logic              is_div;
  logic              neg_a;
  logic              neg_x;
  logic              dz;

  logic              req_ok;
  logic              req_div;
  logic              req_signed;
  logic              sign1;
  logic              sign2;
  logic [DATA_W-1:0] mag1;
  logic [DATA_W-1:0] mag2;

  // Decode the request and take operand magnitudes for the signed funcs
  always_comb begin
    req_ok     = (bus.func == F_MULU) || (bus.func == F_MULS) ||
                 (bus.func == F_DIVU) || (bus.func == F_DIVS);
    req_div    = (bus.func == F_DIVU) || (bus.func == F_DIVS);
    req_signed = (bus.func == F_MULS) || (bus.func == F_DIVS);
    sign1      = req_signed && bus.data1[DATA_W-1];
    sign2      = req_signed && bus.data2[DATA_W-1];
    mag1       = sign1 ? -bus.data1 : bus.data1;
    mag2       = sign2 ? -bus.data2 : bus.data2;
  end

  logic [DATA_W-1:0] mul_addend;
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W:0]   div_shift;
  logic [DATA_W-1:0] div_diff;
  logic              div_ge;
  logic [DATA_W-1:0] step_hi;
  logic [DATA_W-1:0] step_lo;
  logic [DATA_W-1:0] fix_hi;
  logic [DATA_W-1:0] fix_lo;

  // One iteration of either engine, plus the final sign correction.
  // The restoring difference only needs W bits: it is kept only when it fits.
  always_comb begin
    mul_addend = acc_lo[0] ? opnd : {DATA_W{1'b0}};
    mul_sum    = {1'b0, acc_hi} + {1'b0, mul_addend};
    div_shift  = {acc_hi, acc_lo[DATA_W-1]};
    div_ge     = div_shift >= {1'b0, opnd};
    div_diff   = div_shift[DATA_W-1:0] - opnd;
    if (is_div) begin
      step_hi = div_ge ? div_diff : div_shift[DATA_W-1:0];
      step_lo = {acc_lo[DATA_W-2:0], div_ge};
      fix_hi  = neg_a ? -acc_hi : acc_hi;
      fix_lo  = dz ? {DATA_W{1'b1}} : (neg_x ? -acc_lo : acc_lo);
    end else begin
      step_hi = mul_sum[DATA_W:1];
      step_lo = {mul_sum[0], acc_lo[DATA_W-1:1]};
      {fix_hi, fix_lo} = neg_x ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      acc_hi       <= '0;
      acc_lo       <= '0;
      opnd         <= '0;
      is_div       <= 1'b0;
      neg_a        <= 1'b0;
      neg_x        <= 1'b0;
      dz           <= 1'b0;
      bus.busy     <= 1'b0;
      bus.valid    <= 1'b0;
      bus.res_hi   <= '0;
      bus.res_lo   <= '0;
      bus.div_zero <= 1'b0;
    end else if (bus.flush) begin
      state     <= IDLE;
      bus.busy  <= 1'b0;
      bus.valid <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && req_ok) begin
            is_div   <= req_div;
            neg_a    <= sign1;
            neg_x    <= sign1 ^ sign2;
            dz       <= (bus.data2 == '0);
            opnd     <= req_div ? mag2 : mag1;
            acc_hi   <= '0;
            acc_lo   <= req_div ? mag1 : mag2;
            count    <= CNT_W'(DATA_W);
            state    <= RUN;
            bus.busy <= 1'b1;
          end
        end
        RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          count  <= count - CNT_W'(1);
          if (count == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          bus.res_hi   <= fix_hi;
          bus.res_lo   <= fix_lo;
          bus.div_zero <= is_div && dz;
          bus.valid    <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_alu_muldiv.sv
// Directed bench for mips_alu_muldiv: arithmetic results, latency, divide by
// zero, overflow, flush/reset abort and back-to-back throughput.
module tb_mips_alu_muldiv;
  import mips_alu_muldiv_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   fails;

  mips_alu_muldiv_if #(.DATA_W(32)) bus ();

  mips_alu_muldiv #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start one operation at a negedge and count negedges until valid, then
  // step one more cycle so the unit is back in IDLE.
  task automatic run_op(input func_t f, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.func  = f;
    bus.data1 = a;
    bus.data2 = b;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.valid) begin
        lat = i;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks += 5;
    if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
    if (bus.valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid got %b want 0", bus.valid); end
    if (bus.res_hi !== 32'h0) begin fails++; $display("[TB] FAIL reset_hi got %h want 0", bus.res_hi); end
    if (bus.res_lo !== 32'h0) begin fails++; $display("[TB] FAIL reset_lo got %h want 0", bus.res_lo); end
    if (bus.div_zero !== 1'b0) begin fails++; $display("[TB] FAIL reset_dz got %b want 0", bus.div_zero); end
    rst = 1'b0;
  endtask

  task automatic test_mulu();
    int lat;
    run_op(F_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    checks += 4;
    if (lat != 34) begin fails++; $display("[TB] FAIL mulu_latency got %0d want 34", lat); end
    if (bus.res_hi !== 32'hFFFF_FFFE) begin fails++; $display("[TB] FAIL mulu_hi got %h want FFFFFFFE", bus.res_hi); end
    if (bus.res_lo !== 32'h0000_0001) begin fails++; $display("[TB] FAIL mulu_lo got %h want 00000001", bus.res_lo); end
    if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL mulu_idle_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_muls();
    int lat;
    run_op(F_MULS, 32'hFFFF_FFFD, 32'd5, lat);
    checks += 3;
    if (lat != 34) begin fails++; $display("[TB] FAIL muls_latency got %0d want 34", lat); end
    if (bus.res_hi !== 32'hFFFF_FFFF) begin fails++; $display("[TB] FAIL muls_hi got %h want FFFFFFFF", bus.res_hi); end
    if (bus.res_lo !== 32'hFFFF_FFF1) begin fails++; $display("[TB] FAIL muls_lo got %h want FFFFFFF1", bus.res_lo); end
  endtask

  task automatic test_divs();
    int lat;
    run_op(F_DIVS, 32'hFFFF_FFF9, 32'd2, lat);
    checks += 3;
    if (lat != 34) begin fails++; $display("[TB] FAIL divs_latency got %0d want 34", lat); end
    if (bus.res_lo !== 32'hFFFF_FFFD) begin fails++; $display("[TB] FAIL divs_quot got %h want FFFFFFFD", bus.res_lo); end
    if (bus.res_hi !== 32'hFFFF_FFFF) begin fails++; $display("[TB] FAIL divs_rem got %h want FFFFFFFF", bus.res_hi); end
  endtask

  task automatic test_div_zero();
    int lat;
    run_op(F_DIVU, 32'd100, 32'd0, lat);
    checks += 4;
    if (lat != 34) begin fails++; $display("[TB] FAIL dz_latency got %0d want 34", lat); end
    if (bus.res_lo !== 32'hFFFF_FFFF) begin fails++; $display("[TB] FAIL dz_quot got %h want FFFFFFFF", bus.res_lo); end
    if (bus.res_hi !== 32'h0000_0064) begin fails++; $display("[TB] FAIL dz_rem got %h want 00000064", bus.res_hi); end
    if (bus.div_zero !== 1'b1) begin fails++; $display("[TB] FAIL dz_flag got %b want 1", bus.div_zero); end
    run_op(F_DIVU, 32'd100, 32'd7, lat);
    checks += 3;
    if (bus.res_lo !== 32'h0000_000E) begin fails++; $display("[TB] FAIL divu_quot got %h want 0000000E", bus.res_lo); end
    if (bus.res_hi !== 32'h0000_0002) begin fails++; $display("[TB] FAIL divu_rem got %h want 00000002", bus.res_hi); end
    if (bus.div_zero !== 1'b0) begin fails++; $display("[TB] FAIL divu_flag got %b want 0", bus.div_zero); end
  endtask

  task automatic test_flush();
    int nvalid;
    @(negedge clk);
    bus.start = 1'b1;
    bus.func  = F_MULU;
    bus.data1 = 32'h1234_5678;
    bus.data2 = 32'h9ABC_DEF0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL flush_busy got %b want 0", bus.busy); end
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.valid) nvalid++;
    end
    checks += 3;
    if (nvalid != 0) begin fails++; $display("[TB] FAIL flush_valid got %0d pulses want 0", nvalid); end
    if (bus.res_hi !== 32'h0000_0002) begin fails++; $display("[TB] FAIL flush_hold_hi got %h want 00000002", bus.res_hi); end
    if (bus.res_lo !== 32'h0000_000E) begin fails++; $display("[TB] FAIL flush_hold_lo got %h want 0000000E", bus.res_lo); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.start = 1'b1;
    bus.func  = F_MULU;
    bus.data1 = 32'd7;
    bus.data2 = 32'd9;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 4;
    if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_busy got %b want 0", bus.busy); end
    if (bus.res_hi !== 32'h0) begin fails++; $display("[TB] FAIL rstmid_hi got %h want 0", bus.res_hi); end
    if (bus.res_lo !== 32'h0) begin fails++; $display("[TB] FAIL rstmid_lo got %h want 0", bus.res_lo); end
    if (bus.div_zero !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_dz got %b want 0", bus.div_zero); end
  endtask

  task automatic test_overflow_busy_start();
    int nvalid;
    logic [31:0] hi_seen;
    logic [31:0] lo_seen;
    nvalid  = 0;
    hi_seen = 32'hDEAD_BEEF;
    lo_seen = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.start = 1'b1;
    bus.func  = F_DIVS;
    bus.data1 = 32'h8000_0000;
    bus.data2 = 32'hFFFF_FFFF;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      bus.start = (i == 5);
      if (i == 5) begin
        bus.func  = F_MULU;
        bus.data1 = 32'd3;
        bus.data2 = 32'd3;
      end
      if (bus.valid) begin
        nvalid++;
        hi_seen = bus.res_hi;
        lo_seen = bus.res_lo;
      end
    end
    bus.start = 1'b0;
    checks += 3;
    if (nvalid != 1) begin fails++; $display("[TB] FAIL busy_start_valids got %0d want 1", nvalid); end
    if (lo_seen !== 32'h8000_0000) begin fails++; $display("[TB] FAIL ovf_quot got %h want 80000000", lo_seen); end
    if (hi_seen !== 32'h0) begin fails++; $display("[TB] FAIL ovf_rem got %h want 00000000", hi_seen); end
  endtask

  task automatic test_back_to_back();
    int v1;
    int v2;
    v1 = -1;
    v2 = -1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.func  = F_MULU;
    bus.data1 = 32'd3;
    bus.data2 = 32'd4;
    for (int i = 1; i <= 120; i++) begin
      @(negedge clk);
      if (bus.valid) begin
        if (v1 < 0) v1 = i;
        else begin
          v2 = i;
          bus.start = 1'b0;
          break;
        end
      end
    end
    bus.start = 1'b0;
    checks += 3;
    if (v1 != 34) begin fails++; $display("[TB] FAIL b2b_first got %0d want 34", v1); end
    if (v2 - v1 != 35) begin fails++; $display("[TB] FAIL b2b_spacing got %0d want 35", v2 - v1); end
    if (bus.res_lo !== 32'd12) begin fails++; $display("[TB] FAIL b2b_lo got %h want 0000000C", bus.res_lo); end
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL b2b_idle got %b want 0", bus.busy); end
  endtask

  task automatic test_invalid_func();
    @(negedge clk);
    bus.start = 1'b1;
    bus.func  = F_ADD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL add_busy got %b want 0", bus.busy); end
    end
    bus.func  = F_MULU;
    bus.flush = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL flush_start_busy got %b want 0", bus.busy); end
    bus.start = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks    = 0;
    fails     = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.func  = F_ADD;
    bus.data1 = '0;
    bus.data2 = '0;
    test_reset();
    test_mulu();
    test_muls();
    test_divs();
    test_div_zero();
    test_flush();
    test_reset_mid();
    test_overflow_busy_start();
    test_back_to_back();
    test_invalid_func();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
